mux_fifo: RTL and testbench

- Index-steered N-way dataflow multiplexer with a parametrised output FIFO. It replaces the single-slot transparent-buffered mux.
- Each accepted index token selects one data input, consumes it together with the index, and enqueues its data.
- Out-of-range indices are dropped and flagged.
- Sits in handshake circuits wherever a mux feeds a path that needs more than one slot of decoupling.

---
 rtl/mux_fifo.sv | 96 +++++++++
 tb/tb_mux_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_fifo.sv
// Index-steered N-way dataflow multiplexer feeding a circular output FIFO.
// Out-of-range index tokens are consumed without a write and raise a sticky error flag.
module mux_fifo #(
  parameter int SIZE         = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 2,
  parameter int OUT_DEPTH    = 2,
  parameter int COUNT_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SIZE*DATA_WIDTH-1:0] ins,
  input  logic [SIZE-1:0]            ins_valid,
  output logic [SIZE-1:0]            ins_ready,
  input  logic [SELECT_WIDTH-1:0]    index,
  input  logic                       index_valid,
  output logic                       index_ready,
  output logic [DATA_WIDTH-1:0]      outs,
  output logic                       outs_valid,
  input  logic                       outs_ready,
  output logic [COUNT_WIDTH-1:0]     occupancy,
  output logic                       index_error
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_C  = PTR_W'(OUT_DEPTH - 1);

  logic [DATA_WIDTH-1:0]  mem [OUT_DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [COUNT_WIDTH-1:0] count;

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_range, full, push, drop, pop;

  // Decoded by loop so an out-of-range index never indexes past the channel array.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (index == SELECT_WIDTH'(i)) begin
        sel_valid = ins_valid[i];
        sel_data  = ins[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_range = {1'b0, index} < (SELECT_WIDTH + 1)'(SIZE);
  assign full     = (count == DEPTH_C);
  // Full blocks push even when a pop is draining this cycle: keeps outs_ready off the input-side readies.
  assign push     = index_valid & in_range & sel_valid & ~full;
  assign drop     = index_valid & ~in_range;
  assign pop      = outs_valid & outs_ready;

  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = push & (index == SELECT_WIDTH'(i));
    end
  end

  assign index_ready = push | drop;
  assign outs        = mem[head];
  assign outs_valid  = (count != '0);
  assign occupancy   = count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= sel_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      index_error <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) index_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_fifo.sv
// Directed bench for mux_fifo: a 4-way/4-deep instance and a 3-way/3-deep instance
// (the latter exercising wrap-around, full-with-pop and out-of-range indices).
module tb_mux_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: SIZE=4, OUT_DEPTH=4
  logic [31:0] a_ins = '0;
  logic [3:0]  a_ins_valid = '0, a_ins_ready;
  logic [1:0]  a_index = '0;
  logic        a_index_valid = 1'b0, a_index_ready;
  logic [7:0]  a_outs;
  logic        a_outs_valid, a_outs_ready = 1'b0;
  logic [2:0]  a_occupancy;
  logic        a_index_error;

  // Instance B: SIZE=3, OUT_DEPTH=3
  logic [23:0] b_ins = '0;
  logic [2:0]  b_ins_valid = '0, b_ins_ready;
  logic [1:0]  b_index = '0;
  logic        b_index_valid = 1'b0, b_index_ready;
  logic [7:0]  b_outs;
  logic        b_outs_valid, b_outs_ready = 1'b0;
  logic [1:0]  b_occupancy;
  logic        b_index_error;

  mux_fifo #(.SIZE(4), .DATA_WIDTH(8), .SELECT_WIDTH(2), .OUT_DEPTH(4), .COUNT_WIDTH(3)) u_a (
    .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
    .index(a_index), .index_valid(a_index_valid), .index_ready(a_index_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready),
    .occupancy(a_occupancy), .index_error(a_index_error)
  );

  mux_fifo #(.SIZE(3), .DATA_WIDTH(8), .SELECT_WIDTH(2), .OUT_DEPTH(3), .COUNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
    .index(b_index), .index_valid(b_index_valid), .index_ready(b_index_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready),
    .occupancy(b_occupancy), .index_error(b_index_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];
  int model_cnt;
  int k;
  int sent;
  int got_cnt;
  logic [7:0] d;
  bit [4:0] rdy_pat;

  initial begin
    // Reset state
    #2;
    check("rst_a_valid", a_outs_valid, 0);
    check("rst_a_occ", a_occupancy, 0);
    check("rst_a_err", a_index_error, 0);
    check("rst_b_occ", b_occupancy, 0);
    #1 rst = 1'b0;
    tick();

    // Reset mid-stream on A
    a_ins = {8'h13, 8'h12, 8'h11, 8'h10};
    a_ins_valid = 4'hF;
    a_index = 2'd0;
    a_index_valid = 1'b1;
    tick();
    tick();
    a_index_valid = 1'b0;
    check("mid_occ_before", a_occupancy, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", a_outs_valid, 0);
    check("mid_rst_occ", a_occupancy, 0);
    #2 rst = 1'b0;
    tick();
    a_ins = {8'h00, 8'h00, 8'h0B, 8'h0A};
    a_ins_valid = 4'b0011;
    a_index = 2'd1;
    a_index_valid = 1'b1;
    #1;
    check("post_rst_ins_ready", a_ins_ready, 4'b0010);
    check("post_rst_index_ready", a_index_ready, 1);
    tick();
    a_index_valid = 1'b0;
    check("post_rst_outs", a_outs, 8'h0B);
    check("post_rst_valid", a_outs_valid, 1);
    a_outs_ready = 1'b1;
    tick();
    a_outs_ready = 1'b0;
    check("post_rst_drained", a_occupancy, 0);

    // Ordered select 2,0,3,1 into a 4-deep FIFO with the consumer stalled
    a_ins = {8'h13, 8'h12, 8'h11, 8'h10};
    a_ins_valid = 4'hF;
    foreach (exp_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      a_index = (i == 0) ? 2'd2 : (i == 1) ? 2'd0 : (i == 2) ? 2'd3 : 2'd1;
      a_index_valid = 1'b1;
      #1;
      check("ord_index_ready", a_index_ready, 1);
      tick();
    end
    a_index = 2'd0;
    #1;
    check("ord_occ_full", a_occupancy, 4);
    check("ord_full_index_ready", a_index_ready, 0);
    check("ord_full_ins_ready", a_ins_ready, 0);
    tick();
    check("ord_stall_outs", a_outs, 8'h12);
    a_index_valid = 1'b0;
    a_outs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h12 : (i == 1) ? 8'h10 : (i == 2) ? 8'h13 : 8'h11;
      check("ord_drain_valid", a_outs_valid, 1);
      check("ord_drain_outs", a_outs, d);
      tick();
    end
    a_outs_ready = 1'b0;
    check("ord_empty", a_outs_valid, 0);

    // Blocked select: selected channel not valid
    a_index = 2'd1;
    a_index_valid = 1'b1;
    a_ins_valid = 4'b0001;
    #1;
    check("blk_ins_ready", a_ins_ready, 0);
    check("blk_index_ready", a_index_ready, 0);
    tick();
    check("blk_occ", a_occupancy, 0);
    a_ins_valid = 4'b0011;
    #1;
    check("blk_fire_ins_ready", a_ins_ready, 4'b0010);
    check("blk_fire_index_ready", a_index_ready, 1);
    tick();
    a_index_valid = 1'b0;
    check("blk_outs", a_outs, 8'h11);
    check("blk_occ_after", a_occupancy, 1);

    // Full with simultaneous pop on B
    b_ins = {8'h22, 8'h21, 8'h20};
    b_ins_valid = 3'b111;
    b_index_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_index = 2'(i);
      tick();
    end
    b_index = 2'd0;
    b_outs_ready = 1'b1;
    #1;
    check("fp_occ_full", b_occupancy, 3);
    check("fp_index_ready", b_index_ready, 0);
    check("fp_ins_ready", b_ins_ready, 0);
    check("fp_head", b_outs, 8'h20);
    tick();
    check("fp_occ_after_pop", b_occupancy, 2);
    check("fp_resume_index_ready", b_index_ready, 1);
    check("fp_resume_ins_ready", b_ins_ready, 3'b001);
    check("fp_head2", b_outs, 8'h21);
    tick();
    check("fp_steady_occ", b_occupancy, 2);
    check("fp_head3", b_outs, 8'h22);
    tick();
    check("fp_steady_occ2", b_occupancy, 2);
    b_index_valid = 1'b0;
    tick();
    tick();
    b_outs_ready = 1'b0;
    check("fp_drained", b_occupancy, 0);

    // Out-of-range index while full
    b_index_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_index = 2'(i);
      tick();
    end
    b_index = 2'd3;
    #1;
    check("oor_index_ready", b_index_ready, 1);
    check("oor_ins_ready", b_ins_ready, 0);
    check("oor_err_before", b_index_error, 0);
    tick();
    b_index_valid = 1'b0;
    check("oor_occ", b_occupancy, 3);
    check("oor_err_set", b_index_error, 1);
    tick();
    check("oor_err_sticky", b_index_error, 1);
    check("oor_head", b_outs, 8'h20);
    b_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    b_outs_ready = 1'b0;
    check("oor_err_held", b_index_error, 1);

    // Wrap-around stream on B against a scoreboard
    exp_q.delete();
    model_cnt = 0;
    sent = 0;
    got_cnt = 0;
    rdy_pat = 5'b01101;  // bit j = outs_ready on cycle j mod 5: 1,0,1,1,0
    for (int cyc = 0; cyc < 200 && (sent < 10 || exp_q.size() != 0); cyc++) begin
      k = sent;
      for (int j = 0; j < 3; j++) b_ins[j*8 +: 8] = 8'(8'h40 + k + 8'h10 * j);
      b_index = 2'(k % 3);
      b_index_valid = (sent < 10);
      b_outs_ready = rdy_pat[cyc % 5];
      #1;
      check("wr_index_ready", b_index_ready, (sent < 10) && (model_cnt < 3));
      check("wr_outs_valid", b_outs_valid, model_cnt != 0);
      if (model_cnt != 0 && b_outs_ready) begin
        check("wr_outs", b_outs, exp_q[0]);
        void'(exp_q.pop_front());
        model_cnt--;
        got_cnt++;
      end
      if (sent < 10 && (model_cnt + ((model_cnt != 0 && b_outs_ready) ? 1 : 0)) < 3) begin
        exp_q.push_back(8'(8'h40 + k + 8'h10 * (k % 3)));
        model_cnt++;
        sent++;
      end
      tick();
    end
    b_index_valid = 1'b0;
    b_outs_ready = 1'b0;
    check("wr_sent", sent, 10);
    check("wr_received", got_cnt, 10);
    check("wr_final_occ", b_occupancy, 0);

    // Error flag clears only on reset
    #2 rst = 1'b1;
    #1;
    check("final_rst_err", b_index_error, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
